rf_writeback_arbiter: RTL and testbench

- Writer side of the core register file: owns the RF write port (write enable, destination, write data).
- Merges single-cycle ALU results with variable-latency load results, buffering loads in a small FIFO.
- Keeps a pending-load scoreboard so decode can stall on operands whose load has not yet written back.
- Sits between execute/load-unit and the register file; exactly one RF write per cycle at most.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/rf_writeback_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_FIFO,
    WB_BYPASS
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO holding load results awaiting an RF write slot.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      reset_ni,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_next = do_push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = do_pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + 1'b1;
    else if (do_pop && !do_push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_reg[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Owns the RF write port: merges ALU results with buffered loads and tracks pending loads.
module rf_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_rd_i,
  input  logic [XLEN-1:0]       ld_data_i,
  input  logic                  iss_valid_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_i,
  output logic                  regwrite_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       wd_o,
  output logic [XLEN-1:0]       busy_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                  fifo_full, fifo_empty;
  wb_entry_t             fifo_head;
  logic                  force_ld, ld_acc, ld_waiting;
  logic                  push, pop, load_wr;
  wb_src_e               win_src;
  wb_entry_t             win_entry;
  logic [SW-1:0]         starve_reg, starve_next;
  logic                  regwrite_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [XLEN-1:0]       wd_reg;
  logic [XLEN-1:0]       busy_reg, busy_next;
  logic [XLEN-1:0]       set_mask, clr_mask;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .push       (push),
    .push_entry ({ld_rd_i, ld_data_i}),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  assign force_ld    = (starve_reg == SW'(STARVE_MAX)) && !fifo_empty;
  assign alu_ready_o = !force_ld;
  assign ld_ready_o  = !fifo_full;
  assign ld_acc      = ld_valid_i && ld_ready_o;

  always_comb begin
    win_src   = WB_NONE;
    win_entry = '0;
    if (alu_valid_i && !force_ld) begin
      win_src   = WB_ALU;
      win_entry = {alu_rd_i, alu_data_i};
    end else if (!fifo_empty) begin
      win_src   = WB_FIFO;
      win_entry = fifo_head;
    end else if (ld_acc) begin
      win_src   = WB_BYPASS;
      win_entry = {ld_rd_i, ld_data_i};
    end
  end

  assign push    = ld_acc && (win_src != WB_BYPASS);
  assign pop     = (win_src == WB_FIFO);
  assign load_wr = (win_src == WB_FIFO) || (win_src == WB_BYPASS);

  // A load arriving this cycle behind an ALU win already counts as waiting.
  assign ld_waiting = !fifo_empty || push;

  always_comb begin
    starve_next = starve_reg;
    if (pop || !ld_waiting)
      starve_next = '0;
    else if (win_src == WB_ALU && starve_reg != SW'(STARVE_MAX))
      starve_next = starve_reg + 1'b1;
  end

  assign set_mask[0] = 1'b0;
  assign clr_mask[0] = 1'b0;
  for (genvar gi = 1; gi < XLEN; gi++) begin : g_sb
    assign set_mask[gi] = iss_valid_i && (iss_rd_i == REG_ADDR_W'(gi));
    assign clr_mask[gi] = load_wr && (win_entry.rd == REG_ADDR_W'(gi));
  end

  // Set after clear so a re-issue in the same cycle keeps the register pending.
  assign busy_next = (busy_reg & ~clr_mask) | set_mask;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      starve_reg   <= '0;
      busy_reg     <= '0;
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      wd_reg       <= '0;
    end else begin
      starve_reg <= starve_next;
      busy_reg   <= busy_next;
      if (win_src != WB_NONE) begin
        regwrite_reg <= (win_entry.rd != '0);
        rd_reg       <= win_entry.rd;
        wd_reg       <= win_entry.data;
      end else begin
        regwrite_reg <= 1'b0;
      end
    end
  end

  assign regwrite_o = regwrite_reg;
  assign rd_o       = rd_reg;
  assign wd_o       = wd_reg;
  assign busy_o     = busy_reg;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_ni && iss_valid_i && iss_rd_i != '0)
      assert (!busy_reg[iss_rd_i] || clr_mask[iss_rd_i]);
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: expected writes queued at stimulus, popped on regwrite_o.
module tb_rf_writeback_arbiter;
  import wb_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i = '0;
  logic [31:0] ld_data_i = '0;
  logic        iss_valid_i = 1'b0;
  logic [4:0]  iss_rd_i = '0;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;
  logic [31:0] busy_o;

  int total = 0;
  int bad   = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  rf_writeback_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_rd_i     (ld_rd_i),
    .ld_data_i   (ld_data_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .regwrite_o  (regwrite_o),
    .rd_o        (rd_o),
    .wd_o        (wd_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    alu_valid_i = 1'b0;
    ld_valid_i  = 1'b0;
    iss_valid_i = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid_i = 1'b1;
    alu_rd_i    = rd;
    alu_data_i  = d;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid_i = 1'b1;
    ld_rd_i    = rd;
    ld_data_i  = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid_i = 1'b1;
    iss_rd_i    = rd;
  endtask

  always @(negedge clk_i) begin
    if (regwrite_o) begin
      $display("wr x%0d = %h", rd_o, wd_o);
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 32'(regwrite_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_rd", 32'(rd_o), 32'(mon_e.rd));
        chk("wr_data", wd_o, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    #1 reset_ni = 1'b0;
    #1;
    chk("rst_regwrite", 32'(regwrite_o), 32'd0);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready_o), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready_o), 32'd1);
    repeat (3) tick();
    reset_ni = 1'b1;
    tick();

    // Single ALU write, one-cycle latency
    drive_alu(5'd5, 32'hDEADBEEF);
    chk("t1_alu_ready", 32'(alu_ready_o), 32'd1);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    chk("t1_regwrite", 32'(regwrite_o), 32'd1);
    chk("t1_rd", 32'(rd_o), 32'd5);
    chk("t1_wd", wd_o, 32'hDEADBEEF);
    tick();

    // ALU and load collide with empty FIFO: ALU first, load next
    issue(5'd7);
    tick();
    idle();
    chk("t2_busy_set", busy_o, 32'h0000_0080);
    drive_alu(5'd3, 32'h11);
    drive_ld(5'd7, 32'h22);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd7, 32'h22);
    tick();
    idle();
    chk("t2_n1_rd", 32'(rd_o), 32'd3);
    chk("t2_n1_busy", busy_o, 32'h0000_0080);
    tick();
    chk("t2_n2_regwrite", 32'(regwrite_o), 32'd1);
    chk("t2_n2_rd", 32'(rd_o), 32'd7);
    chk("t2_n2_wd", wd_o, 32'h22);
    tick();
    chk("t2_n3_busy", busy_o, 32'd0);
    tick();

    // Starvation: ALU every cycle, two loads; force every STARVE_MAX ALU wins
    for (int i = 0; i < 4; i++) expect_wr(5'(16 + i), 32'hA000_0000 + 32'(i));
    expect_wr(5'd20, 32'hB000_0000);
    for (int i = 4; i < 8; i++) expect_wr(5'(16 + i), 32'hA000_0000 + 32'(i));
    expect_wr(5'd21, 32'hB000_0001);
    k = 0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      if (k < 8) drive_alu(5'(16 + k), 32'hA000_0000 + 32'(k));
      else alu_valid_i = 1'b0;
      if (c < 2) drive_ld(5'(20 + c), 32'hB000_0000 + 32'(c));
      else ld_valid_i = 1'b0;
      if (c < 2) chk("t3_ld_ready_early", 32'(ld_ready_o), 32'd1);
      if (c == 2) chk("t3_ld_ready_full", 32'(ld_ready_o), 32'd0);
      if (c < 4) chk("t3_alu_ready_win", 32'(alu_ready_o), 32'd1);
      if (c == 4) chk("t3_alu_ready_forced", 32'(alu_ready_o), 32'd0);
      if (c == 5) begin
        chk("t3_ld_ready_back", 32'(ld_ready_o), 32'd1);
        chk("t3_load_rd", 32'(rd_o), 32'd20);
      end
      acc = alu_valid_i && alu_ready_o;
      tick();
      if (acc) k++;
    end
    idle();
    tick();

    // rd 0 writers are consumed silently; rd 0 issue sets nothing
    drive_alu(5'd0, 32'hFFFF_FFFF);
    issue(5'd0);
    tick();
    idle();
    drive_ld(5'd0, 32'h1234_5678);
    chk("t4_alu_rd0_regwrite", 32'(regwrite_o), 32'd0);
    tick();
    idle();
    chk("t4_ld_rd0_regwrite", 32'(regwrite_o), 32'd0);
    chk("t4_busy", busy_o, 32'd0);
    tick();
    chk("t4_ld_ready", 32'(ld_ready_o), 32'd1);
    chk("t4_idle_regwrite", 32'(regwrite_o), 32'd0);

    // Same-cycle clear and re-issue of x9 keeps it busy
    issue(5'd9);
    tick();
    idle();
    chk("t5_busy_set", busy_o, 32'h0000_0200);
    drive_alu(5'd1, 32'h5151);
    drive_ld(5'd9, 32'h9001);
    expect_wr(5'd1, 32'h5151);
    expect_wr(5'd9, 32'h9001);
    tick();
    idle();
    issue(5'd9);
    chk("t5_alu_rd", 32'(rd_o), 32'd1);
    tick();
    idle();
    chk("t5_busy_kept", busy_o, 32'h0000_0200);
    chk("t5_pop_rd", 32'(rd_o), 32'd9);
    drive_ld(5'd9, 32'h9002);
    expect_wr(5'd9, 32'h9002);
    tick();
    idle();
    chk("t5_bypass_wd", wd_o, 32'h9002);
    tick();
    chk("t5_busy_clear", busy_o, 32'd0);
    tick();

    // Reset mid-operation discards buffered loads and scoreboard
    issue(5'd7);
    tick();
    issue(5'd9);
    tick();
    idle();
    drive_alu(5'd2, 32'hA1);
    drive_ld(5'd7, 32'h7777);
    expect_wr(5'd2, 32'hA1);
    tick();
    drive_alu(5'd4, 32'hA2);
    drive_ld(5'd9, 32'h9999);
    chk("t6_ld_ready_one", 32'(ld_ready_o), 32'd1);
    tick();
    idle();
    chk("t6_busy_pre", busy_o, 32'h0000_0280);
    chk("t6_full_pre", 32'(ld_ready_o), 32'd0);
    chk("t6_rd_pre", 32'(rd_o), 32'd4);
    reset_ni = 1'b0;
    #1;
    chk("t6_rst_regwrite", 32'(regwrite_o), 32'd0);
    chk("t6_rst_busy", busy_o, 32'd0);
    chk("t6_rst_ld_ready", 32'(ld_ready_o), 32'd1);
    tick();
    tick();
    reset_ni = 1'b1;
    repeat (6) tick();
    chk("t6_post_busy", busy_o, 32'd0);
    chk("t6_post_ld_ready", 32'(ld_ready_o), 32'd1);
    chk("t6_post_regwrite", 32'(regwrite_o), 32'd0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
